// File: rtl/fill_pulse_monitor.sv
// ---------------------------------------------------------------------------
// fill_pulse_monitor
//
// Receive-side checker for the full-level indicator `sig` from the load/store
// fill/drain producer. Each clock it samples `sig`, tracks how long each high
// run lasts and how far apart pulse onsets are, and counts onsets. It raises
// sticky error flags on overlong high runs and on wrong periods. It reports
// lock once enough consecutive correct periods have been seen.
//
// Parameters
//   CBITS      : width of the period counter and of `period`
//   EXP_PERIOD : required onset-to-onset distance in clock cycles
//   MAX_HIGH   : largest legal number of consecutive high samples
//   LOCK_COUNT : consecutive correct periods needed for `locked` (>= 1)
//
// Ports
//   clk          : clock, everything samples on the rising edge
//   rst_n        : asynchronous active-low reset
//   sig          : full indicator from the producer, synchronous to clk
//   pulse_cnt    : number of onsets seen, wraps modulo 2^16
//   period       : last measured onset-to-onset distance, saturating
//   period_valid : one-cycle strobe, `period` was updated this cycle
//   err_width    : sticky, a high run exceeded MAX_HIGH samples
//   err_period   : sticky, a measured period differed from EXP_PERIOD
//   locked       : LOCK_COUNT consecutive good periods with no error event
// ---------------------------------------------------------------------------
module fill_pulse_monitor #(
    parameter int CBITS      = 17,
    parameter int EXP_PERIOD = 50002,
    parameter int MAX_HIGH   = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    output logic [15:0]      pulse_cnt,
    output logic [CBITS-1:0] period,
    output logic             period_valid,
    output logic             err_width,
    output logic             err_period,
    output logic             locked
);

    // The run counter must reach MAX_HIGH+1, the good-period counter must
    // reach LOCK_COUNT.
    localparam int RBITS = $clog2(MAX_HIGH + 2);
    localparam int GBITS = $clog2(LOCK_COUNT + 1);

    localparam logic [RBITS-1:0] RUN_LIMIT = RBITS'(MAX_HIGH + 1);
    localparam logic [GBITS-1:0] GOOD_MAX  = GBITS'(LOCK_COUNT);
    localparam logic [CBITS-1:0] EXP_P     = CBITS'(EXP_PERIOD);
    localparam logic [CBITS-1:0] PER_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             prev_sig;
    logic [RBITS-1:0] run_cnt, run_cnt_nxt;
    logic [CBITS-1:0] per_cnt, per_cnt_nxt;
    logic             per_sat, per_sat_nxt;
    logic [GBITS-1:0] good_cnt, good_cnt_nxt;

    logic [15:0]      pulse_cnt_nxt;
    logic [CBITS-1:0] period_nxt;
    logic             period_valid_nxt;
    logic             err_width_nxt;
    logic             err_period_nxt;
    logic             locked_nxt;

    logic             onset;
    logic             start;
    logic             measure;
    logic             width_evt;
    logic             period_evt;
    logic             good_evt;
    logic [RBITS-1:0] run_inc;

    // Next-state and next-output logic. An onset restarts the period counter
    // at 1, so the counter value seen at the next onset equals the number of
    // clock edges between the two onset samples. The separate per_sat flag
    // lets a true distance of exactly PER_MAX be told apart from an overflow:
    // an overflowed measurement is always reported as a period error.
    always_comb begin
        state_nxt        = state;
        run_cnt_nxt      = run_cnt;
        per_cnt_nxt      = per_cnt;
        per_sat_nxt      = per_sat;
        good_cnt_nxt     = good_cnt;
        pulse_cnt_nxt    = pulse_cnt;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        start            = 1'b0;
        measure          = 1'b0;
        width_evt        = 1'b0;
        period_evt       = 1'b0;
        good_evt         = 1'b0;
        onset            = sig & ~prev_sig;
        run_inc          = run_cnt + 1'b1;

        // Once the first onset has been seen the period counter runs freely
        // until it saturates.
        if (state != IDLE) begin
            if (per_cnt == PER_MAX) begin
                per_sat_nxt = 1'b1;
            end else begin
                per_cnt_nxt = per_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (onset) begin
                    state_nxt = HIGH;
                    start     = 1'b1;
                end
            end
            HIGH: begin
                if (!sig) begin
                    state_nxt = LOW;
                end else if (run_cnt != RUN_LIMIT) begin
                    // The run counter stops at the limit, so one overlong
                    // run produces exactly one error event.
                    run_cnt_nxt = run_inc;
                    if (run_inc == RUN_LIMIT) begin
                        width_evt = 1'b1;
                    end
                end
            end
            LOW: begin
                if (onset) begin
                    state_nxt = HIGH;
                    start     = 1'b1;
                    measure   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (start) begin
            pulse_cnt_nxt = pulse_cnt + 16'd1;
            per_cnt_nxt   = {{(CBITS-1){1'b0}}, 1'b1};
            per_sat_nxt   = 1'b0;
            run_cnt_nxt   = {{(RBITS-1){1'b0}}, 1'b1};
            if (RUN_LIMIT == {{(RBITS-1){1'b0}}, 1'b1}) begin
                width_evt = 1'b1;
            end
        end

        if (measure) begin
            period_valid_nxt = 1'b1;
            period_nxt       = per_cnt;
            if (per_sat || (per_cnt != EXP_P)) begin
                period_evt = 1'b1;
            end else begin
                good_evt = 1'b1;
            end
        end

        // An error event wins over a good period arriving in the same cycle.
        if (width_evt || period_evt) begin
            good_cnt_nxt = '0;
        end else if (good_evt && (good_cnt != GOOD_MAX)) begin
            good_cnt_nxt = good_cnt + 1'b1;
        end

        err_width_nxt  = err_width | width_evt;
        err_period_nxt = err_period | period_evt;
        locked_nxt     = (good_cnt_nxt == GOOD_MAX);
    end

    // State register. Every output is registered here, so the effect of the
    // sample taken at an edge appears right after that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_sig     <= 1'b0;
            run_cnt      <= '0;
            per_cnt      <= '0;
            per_sat      <= 1'b0;
            good_cnt     <= '0;
            pulse_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            err_width    <= 1'b0;
            err_period   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev_sig     <= sig;
            run_cnt      <= run_cnt_nxt;
            per_cnt      <= per_cnt_nxt;
            per_sat      <= per_sat_nxt;
            good_cnt     <= good_cnt_nxt;
            pulse_cnt    <= pulse_cnt_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            err_width    <= err_width_nxt;
            err_period   <= err_period_nxt;
            locked       <= locked_nxt;
        end
    end

endmodule

// File: tb/tb_fill_pulse_monitor.sv
// ---------------------------------------------------------------------------
// tb_fill_pulse_monitor
//
// Directed bench for fill_pulse_monitor with EXP_PERIOD=10, LOCK_COUNT=2,
// MAX_HIGH=2 and CBITS=5. Expected values are worked out by hand for each
// step of the pulse trains below.
// ---------------------------------------------------------------------------
module tb_fill_pulse_monitor;

    logic        clk;
    logic        rst_n;
    logic        sig;
    logic [15:0] pulse_cnt;
    logic [4:0]  period;
    logic        period_valid;
    logic        err_width;
    logic        err_period;
    logic        locked;

    int checks = 0;
    int errors = 0;

    fill_pulse_monitor #(
        .CBITS      (5),
        .EXP_PERIOD (10),
        .MAX_HIGH   (2),
        .LOCK_COUNT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig          (sig),
        .pulse_cnt    (pulse_cnt),
        .period       (period),
        .period_valid (period_valid),
        .err_width    (err_width),
        .err_period   (err_period),
        .locked       (locked)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one sample, let the DUT take it, and return just after the edge
    // so outputs can be read away from the clock edge.
    task automatic applyStimulus(input logic val);
        sig = val;
        @(posedge clk);
        #1;
    endtask

    // Remaining high samples of a pulse followed by its low gap.
    task automatic finishPulse(input int more_high, input int low);
        for (int i = 0; i < more_high; i++) applyStimulus(1'b1);
        for (int i = 0; i < low; i++) applyStimulus(1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pulse_cnt", 32'(pulse_cnt), 0);
        checkOutput("rst_period", 32'(period), 0);
        checkOutput("rst_pv", 32'(period_valid), 0);
        checkOutput("rst_err_width", 32'(err_width), 0);
        checkOutput("rst_err_period", 32'(err_period), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal train: 2 high, 8 low.
        $display("[TB] ideal train");
        applyStimulus(1'b1);
        checkOutput("t1_o1_cnt", 32'(pulse_cnt), 1);
        checkOutput("t1_o1_pv", 32'(period_valid), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t1_o2_cnt", 32'(pulse_cnt), 2);
        checkOutput("t1_o2_period", 32'(period), 10);
        checkOutput("t1_o2_pv", 32'(period_valid), 1);
        checkOutput("t1_o2_locked", 32'(locked), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t1_o3_cnt", 32'(pulse_cnt), 3);
        checkOutput("t1_o3_period", 32'(period), 10);
        checkOutput("t1_o3_pv", 32'(period_valid), 1);
        checkOutput("t1_o3_locked", 32'(locked), 1);
        applyStimulus(1'b1);
        checkOutput("t1_pv_drop", 32'(period_valid), 0);
        checkOutput("t1_err_width", 32'(err_width), 0);
        checkOutput("t1_err_period", 32'(err_period), 0);
        finishPulse(0, 8);

        // Overlong pulse: 3 high, 7 low keeps the period at 10.
        $display("[TB] overlong pulse");
        applyStimulus(1'b1);
        checkOutput("t2_o4_cnt", 32'(pulse_cnt), 4);
        checkOutput("t2_o4_locked", 32'(locked), 1);
        applyStimulus(1'b1);
        checkOutput("t2_high2_err", 32'(err_width), 0);
        checkOutput("t2_high2_locked", 32'(locked), 1);
        applyStimulus(1'b1);
        checkOutput("t2_high3_err", 32'(err_width), 1);
        checkOutput("t2_high3_locked", 32'(locked), 0);
        finishPulse(0, 7);
        applyStimulus(1'b1);
        checkOutput("t2_o5_period", 32'(period), 10);
        checkOutput("t2_o5_locked", 32'(locked), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t2_o6_cnt", 32'(pulse_cnt), 6);
        checkOutput("t2_o6_locked", 32'(locked), 1);
        checkOutput("t2_o6_err_width", 32'(err_width), 1);
        checkOutput("t2_o6_err_period", 32'(err_period), 0);
        finishPulse(1, 8);

        // Short gap: one period of 9.
        $display("[TB] short period");
        applyStimulus(1'b1);
        checkOutput("t3_o7_locked", 32'(locked), 1);
        finishPulse(1, 7);
        applyStimulus(1'b1);
        checkOutput("t3_o8_period", 32'(period), 9);
        checkOutput("t3_o8_pv", 32'(period_valid), 1);
        checkOutput("t3_o8_err_period", 32'(err_period), 1);
        checkOutput("t3_o8_locked", 32'(locked), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t3_o9_period", 32'(period), 10);
        checkOutput("t3_o9_locked", 32'(locked), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t3_o10_cnt", 32'(pulse_cnt), 10);
        checkOutput("t3_o10_locked", 32'(locked), 1);

        // Reset in the middle of a pulse while locked.
        $display("[TB] reset mid-pulse");
        rst_n = 1'b0;
        #1;
        checkOutput("t5_cnt", 32'(pulse_cnt), 0);
        checkOutput("t5_period", 32'(period), 0);
        checkOutput("t5_locked", 32'(locked), 0);
        checkOutput("t5_err_width", 32'(err_width), 0);
        checkOutput("t5_err_period", 32'(err_period), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // sig already high on the first sample after release.
        applyStimulus(1'b1);
        checkOutput("t6_o1_cnt", 32'(pulse_cnt), 1);
        checkOutput("t6_o1_pv", 32'(period_valid), 0);
        finishPulse(1, 8);
        applyStimulus(1'b1);
        checkOutput("t6_o2_cnt", 32'(pulse_cnt), 2);
        checkOutput("t6_o2_period", 32'(period), 10);
        checkOutput("t6_o2_pv", 32'(period_valid), 1);
        checkOutput("t6_o2_err_period", 32'(err_period), 0);

        // Gap of 42 cycles overflows the 5-bit period counter.
        $display("[TB] saturated period");
        finishPulse(1, 40);
        applyStimulus(1'b1);
        checkOutput("t4_period", 32'(period), 31);
        checkOutput("t4_pv", 32'(period_valid), 1);
        checkOutput("t4_err_period", 32'(err_period), 1);
        checkOutput("t4_locked", 32'(locked), 0);
        checkOutput("t4_cnt", 32'(pulse_cnt), 3);
        finishPulse(1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
